frame_scanout: RTL and testbench
================================

Name: frame_scanout

Overview:
- Read-side client of the 160x120x12 frame buffer.
- Generates 640x480@60 VGA timing from a 25.175 MHz pixel clock and drives the buffer's read address.
- Upscales 4x in both axes (pixel replication) and outputs 4:4:4 RGB with hsync/vsync aligned to the buffer's 1-cycle registered read latency.
- Sits between the frame buffer read port (same clock domain as clk_read) and the board VGA pins.

Parameters:
- ADDR_WIDTH, 15, frame buffer address width (matches buffer config addr_width).
- FB_WIDTH, 160, buffer pixels per row.
- SCALE_SHIFT, 2, log2 of the upscale factor (4x).
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, hsync width.
- H_BP, 48, horizontal back porch.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vsync width.
- V_BP, 33, vertical back porch.

Ports:
- clk  in  1  pixel clock; same clock as the frame buffer read clock.
- rstn  in  1  asynchronous active-low reset.
- enable  in  1  scanout run; low holds the counters at the frame origin.
- read_addr  out  ADDR_WIDTH  frame buffer read address.
- read_data  in  12 (color_t)  frame buffer data, valid 1 cycle after read_addr.
- vga_r  out  4  red.
- vga_g  out  4  green.
- vga_b  out  4  blue.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- active  out  1  output pixel is in the visible area.
- frame_start  out  1  one-cycle pulse coincident with output pixel (0,0).

Behaviour:
- **Reset values:** h_cnt=0, v_cnt=0, row_base=0, read_addr=0, rgb=0, hsync=1, vsync=1, active=0, frame_start=0. All pipeline stages are cleared.
- **Counters:**
  - h_cnt runs 0..H_TOTAL-1 (800), then wraps to 0 and advances v_cnt.
  - v_cnt runs 0..V_TOTAL-1 (525), then wraps to 0.
  - Counters advance only while enable=1.
  - When enable=0, counters go to 0 on the next edge, and outputs go to reset values after the pipeline drains (3 cycles).
- **Addressing (no multiplier):**
  - row_base is a register.
  - At the last cycle of a line (h_cnt=H_TOTAL-1) it adds FB_WIDTH if v_cnt<V_ACTIVE-1 and v_cnt[SCALE_SHIFT-1:0]=all ones.
  - At the last cycle of the frame it clears to 0.
  - Stage-1 register: read_addr <= row_base + (h_cnt>>SCALE_SHIFT) when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; otherwise 0.
  - Maximum address is 19199; it never exceeds FB_WIDTH*FB_HEIGHT-1.
- **Pipeline (latency 3):**
  - Counters hold (h,v) at cycle T.
  - read_addr is visible at T+1.
  - read_data is visible at T+2.
  - vga_r/g/b, hsync, vsync, active and frame_start for (h,v) are all visible at T+3.
  - hsync/vsync/active travel through a 3-deep delay line so sync and colour stay aligned.
- **Sync regions (counter values):**
  - hsync=0 for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
  - vsync=0 for v in 490..491.
- **Blanking:** rgb is forced to 0 whenever the delayed active=0.
- **Colour unpack:** vga_r = read_data[11:8], vga_g = read_data[7:4], vga_b = read_data[3:0].
- **Reset mid-frame:** everything returns to reset values asynchronously. Scanout restarts at (0,0) after rstn deasserts, with the first frame_start 3 cycles after the first enabled edge.
- **Writes during scanout:** permitted. Tearing is accepted; there is no double buffering in this block.

Optional Feature:
- Macro: FRAME_SCANOUT_BORDER_EN.
- Defined: output pixels on the visible edge (h=0, h=H_ACTIVE-1, v=0, v=V_ACTIVE-1) are forced to 12'hFFF (white), overriding read_data, with identical latency. Used for monitor alignment.
- Undefined: no override logic is present; output is pure buffer data.

Decomposition:
- Shared package (types_pkg):
  - vga_timing_t struct holding active/fp/sync/bp for each axis.
  - VGA_640x480 constant.
  - Existing color_t.
- Sub-module vga_timing_gen owns h/v counters, raw sync/active and end-of-line/end-of-frame strobes. frame_scanout owns addressing, the delay line and colour output.

Test Plan:
- **Reset:** hold rstn=0 -> hsync=1, vsync=1, rgb=0, read_addr=0. Release with enable=1 -> frame_start pulses exactly on cycle 3, with active=1.
- **Addressing:** buffer model filled with addr-dependent data.
  - Check read_addr=0 for h 0..3 on line 0.
  - Check read_addr=1 at h=4, v=0.
  - Check read_addr=160 at h=0, v=4.
  - Check read_addr=19199 at (639,479).
  - Output rgb equals model[addr] 3 cycles after the counter value.
- **Timing:**
  - Measure hsync low 96 cycles starting at counter 656, period 800.
  - Measure vsync low 2 lines, period 525 lines.
  - rgb=0 whenever active=0.
- **Replication:** buffer pixel 0 = 12'hF00, pixel 1 = 12'h0F0 -> output lines 0..3 show 4 red then 4 green pixels.
- **Enable:** drop enable mid-line at h=300 -> after 3 cycles outputs are at reset values. Re-assert -> frame_start 3 cycles later.
- **Border (FRAME_SCANOUT_BORDER_EN defined, buffer all 12'h000):**
  - Row 0 and column 639 output 12'hFFF.
  - Pixel (1,1) outputs 12'h000.

Source files
------------

// File: rtl/types_pkg.sv
// Shared VGA scanout types: per-axis timing descriptor, the 640x480@60 preset,
// the 4:4:4 colour word and the control bundle carried down the scanout pipeline.
package types_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } color_t;

    typedef struct packed {
        logic [10:0] active;
        logic [10:0] fp;
        logic [10:0] sync;
        logic [10:0] bp;
    } vga_axis_t;

    typedef struct packed {
        vga_axis_t h;
        vga_axis_t v;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x480 = '{
        h: '{active: 11'd640, fp: 11'd16, sync: 11'd96, bp: 11'd48},
        v: '{active: 11'd480, fp: 11'd10, sync: 11'd2,  bp: 11'd33}
    };

    // Horizontal and vertical counters share one width; 800 and 525 both fit.
    localparam int CNT_W = 10;

    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
        logic frame_start;
    } scan_ctl_t;

    localparam scan_ctl_t SCAN_CTL_IDLE = '{active: 1'b0, hsync: 1'b1, vsync: 1'b1, frame_start: 1'b0};

    function automatic int axis_total(input vga_axis_t a);
        return int'(a.active) + int'(a.fp) + int'(a.sync) + int'(a.bp);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// VGA raster counters with raw (undelayed) sync/active and end-of-line/frame strobes.
// All raw outputs read as idle while enable is low.
module vga_timing_gen
    import types_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             active_raw,
    output logic             hsync_raw,
    output logic             vsync_raw,
    output logic             line_end,
    output logic             frame_end
);

    localparam vga_axis_t H_AXIS = '{active: 11'(H_ACTIVE), fp: 11'(H_FP), sync: 11'(H_SYNC), bp: 11'(H_BP)};
    localparam vga_axis_t V_AXIS = '{active: 11'(V_ACTIVE), fp: 11'(V_FP), sync: 11'(V_SYNC), bp: 11'(V_BP)};

    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(axis_total(H_AXIS) - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(axis_total(V_AXIS) - 1);
    localparam logic [CNT_W-1:0] H_VIS     = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS     = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!enable) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
        end else begin
            h_cnt <= h_cnt + CNT_W'(1);
        end
    end

    assign line_end   = enable && (h_cnt == H_LAST);
    assign frame_end  = line_end && (v_cnt == V_LAST);
    assign active_raw = enable && (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign hsync_raw  = !(enable && (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
    assign vsync_raw  = !(enable && (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));

endmodule

// File: rtl/frame_scanout.sv
// Frame buffer read client: 4x pixel-replicated VGA scanout with a 3-cycle pipeline.
// Define FRAME_SCANOUT_BORDER_EN to force the outermost visible pixels to white.
module frame_scanout
    import types_pkg::*;
#(
    parameter int ADDR_WIDTH  = 15,
    parameter int FB_WIDTH    = 160,
    parameter int SCALE_SHIFT = 2,
    parameter int H_ACTIVE    = int'(VGA_640x480.h.active),
    parameter int H_FP        = int'(VGA_640x480.h.fp),
    parameter int H_SYNC      = int'(VGA_640x480.h.sync),
    parameter int H_BP        = int'(VGA_640x480.h.bp),
    parameter int V_ACTIVE    = int'(VGA_640x480.v.active),
    parameter int V_FP        = int'(VGA_640x480.v.fp),
    parameter int V_SYNC      = int'(VGA_640x480.v.sync),
    parameter int V_BP        = int'(VGA_640x480.v.bp)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  color_t                read_data,
    output logic [3:0]            vga_r,
    output logic [3:0]            vga_g,
    output logic [3:0]            vga_b,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  active,
    output logic                  frame_start
);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             active_raw;
    logic             hsync_raw;
    logic             vsync_raw;
    logic             line_end;
    logic             frame_end;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (enable),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .active_raw (active_raw),
        .hsync_raw  (hsync_raw),
        .vsync_raw  (vsync_raw),
        .line_end   (line_end),
        .frame_end  (frame_end)
    );

    localparam logic [CNT_W-1:0] V_STEP_LIMIT = CNT_W'(V_ACTIVE - 1);

    // row_base accumulates FB_WIDTH once per SCALE output lines, avoiding a v*FB_WIDTH multiply.
    logic [ADDR_WIDTH-1:0] row_base;
    logic                  row_step;

    assign row_step = (v_cnt < V_STEP_LIMIT) && (&v_cnt[SCALE_SHIFT-1:0]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_base <= '0;
        end else if (!enable || frame_end) begin
            row_base <= '0;
        end else if (line_end && row_step) begin
            row_base <= row_base + ADDR_WIDTH'(FB_WIDTH);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            read_addr <= '0;
        end else if (active_raw) begin
            read_addr <= row_base + ADDR_WIDTH'(h_cnt >> SCALE_SHIFT);
        end else begin
            read_addr <= '0;
        end
    end

    scan_ctl_t ctl_raw;
    scan_ctl_t ctl_d1;
    scan_ctl_t ctl_d2;
    scan_ctl_t ctl_d3;
    color_t    pixel_next;
    color_t    pixel_q;

    always_comb begin
        ctl_raw             = SCAN_CTL_IDLE;
        ctl_raw.active      = active_raw;
        ctl_raw.hsync       = hsync_raw;
        ctl_raw.vsync       = vsync_raw;
        ctl_raw.frame_start = enable && (h_cnt == '0) && (v_cnt == '0);
    end

`ifdef FRAME_SCANOUT_BORDER_EN
    localparam logic [CNT_W-1:0] H_LAST_VIS = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_LAST_VIS = CNT_W'(V_ACTIVE - 1);

    logic border_raw;
    logic border_d1;
    logic border_d2;

    assign border_raw = active_raw && ((h_cnt == '0) || (h_cnt == H_LAST_VIS) ||
                                       (v_cnt == '0) || (v_cnt == V_LAST_VIS));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            border_d1 <= 1'b0;
            border_d2 <= 1'b0;
        end else begin
            border_d1 <= border_raw;
            border_d2 <= border_d1;
        end
    end
`endif

    // ctl_d2 lines up with read_data, so colour and control leave the output stage together.
    always_comb begin
        pixel_next = read_data;
`ifdef FRAME_SCANOUT_BORDER_EN
        if (border_d2) begin
            pixel_next = color_t'(12'hFFF);
        end
`endif
        if (!ctl_d2.active) begin
            pixel_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctl_d1  <= SCAN_CTL_IDLE;
            ctl_d2  <= SCAN_CTL_IDLE;
            ctl_d3  <= SCAN_CTL_IDLE;
            pixel_q <= '0;
        end else begin
            ctl_d1  <= ctl_raw;
            ctl_d2  <= ctl_d1;
            ctl_d3  <= ctl_d2;
            pixel_q <= pixel_next;
        end
    end

    assign vga_r       = pixel_q.r;
    assign vga_g       = pixel_q.g;
    assign vga_b       = pixel_q.b;
    assign hsync       = ctl_d3.hsync;
    assign vsync       = ctl_d3.vsync;
    assign active      = ctl_d3.active;
    assign frame_start = ctl_d3.frame_start;

endmodule

// File: tb/tb_frame_scanout.sv
// Bench for frame_scanout: a full-size 640x480 instance checked by a raster-model scoreboard,
// plus a reduced-timing instance used for whole-frame measurements.
`timescale 1ns/1ps
module tb_frame_scanout;
    import types_pkg::*;

    localparam int AW = 15;
    localparam int FBW = 160, HA = 640, HFP = 16, HS = 96, HBP = 48;
    localparam int VA = 480, VFP = 10, VS = 2, VBP = 33;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;

    // clock / reset
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic enable = 1'b0;
    logic s_en = 1'b0;
    always #20 clk = ~clk;

    logic [AW-1:0] read_addr, s_read_addr;
    color_t        read_data, s_read_data;
    logic [3:0]    vga_r, vga_g, vga_b, s_r, s_g, s_b;
    logic          hsync, vsync, active, frame_start;
    logic          s_hsync, s_vsync, s_active, s_frame_start;
    logic [11:0]   mem [0:(1<<AW)-1];

    frame_scanout u_dut (
        .clk(clk), .rstn(rstn), .enable(enable), .read_addr(read_addr), .read_data(read_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .hsync(hsync), .vsync(vsync),
        .active(active), .frame_start(frame_start)
    );

    // 24x12 raster, 16x8 visible, 4x2 buffer: a whole frame is 288 cycles.
    frame_scanout #(
        .ADDR_WIDTH(AW), .FB_WIDTH(4), .SCALE_SHIFT(2),
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_small (
        .clk(clk), .rstn(rstn), .enable(s_en), .read_addr(s_read_addr), .read_data(s_read_data),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .hsync(s_hsync), .vsync(s_vsync),
        .active(s_active), .frame_start(s_frame_start)
    );

    // frame buffer read ports: one registered cycle
    always @(posedge clk) begin
        read_data   <= color_t'(mem[read_addr]);
        s_read_data <= color_t'(mem[s_read_addr]);
    end

    // scoreboard
    typedef struct packed {
        logic          en;
        logic [9:0]    h;
        logic [9:0]    v;
        logic [AW-1:0] addr;
        logic [11:0]   rgb;
        logic          hs;
        logic          vs;
        logic          act;
        logic          fs;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);
    localparam exp_t IDLE = '{en: 1'b0, h: '0, v: '0, addr: '0, rgb: '0, hs: 1'b1, vs: 1'b1, act: 1'b0, fs: 1'b0};

    logic [EXP_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int mh = 0, mv = 0;
    int last_h = 0, last_v = 0, out_h = 0, out_v = 0;
    logic last_en = 1'b0, out_en = 1'b0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic exp_t expect_at(input int h, input int v, input logic en);
        exp_t e;
        e = IDLE;
        e.en = en;
        e.h = 10'(h);
        e.v = 10'(v);
        if (en) begin
            e.act = (h < HA) && (v < VA);
            e.hs  = !((h >= HA + HFP) && (h < HA + HFP + HS));
            e.vs  = !((v >= VA + VFP) && (v < VA + VFP + VS));
            e.fs  = (h == 0) && (v == 0);
            if (e.act) begin
                e.addr = AW'((v / 4) * FBW + h / 4);
                e.rgb  = mem[e.addr];
`ifdef FRAME_SCANOUT_BORDER_EN
                if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) e.rgb = 12'hFFF;
`endif
            end
        end
        return e;
    endfunction

    // raster model: one expected entry per clock, pushed for the counter state just ended
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            exp_q.delete();
            exp_q.push_back(EXP_W'(IDLE));
            exp_q.push_back(EXP_W'(IDLE));
            mh <= 0;
            mv <= 0;
            last_en <= 1'b0;
        end else begin
            exp_q.push_back(EXP_W'(expect_at(mh, mv, enable)));
            last_h  <= mh;
            last_v  <= mv;
            last_en <= enable;
            if (!enable) begin
                mh <= 0;
                mv <= 0;
            end else if (mh == HT - 1) begin
                mh <= 0;
                mv <= (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh <= mh + 1;
            end
        end
    end

    // monitor: newest entry owns read_addr, oldest of three owns the pixel outputs
    always @(negedge clk) begin
        if (rstn && exp_q.size() >= 3) begin
            exp_t e;
            e = exp_t'(exp_q[exp_q.size() - 1]);
            check("read_addr", int'(read_addr), int'(e.addr));
            e = exp_t'(exp_q.pop_front());
            check("rgb", int'({vga_r, vga_g, vga_b}), int'(e.rgb));
            check("hsync", int'(hsync), int'(e.hs));
            check("vsync", int'(vsync), int'(e.vs));
            check("active", int'(active), int'(e.act));
            check("frame_start", int'(frame_start), int'(e.fs));
            if (!active) check("blank_rgb", int'({vga_r, vga_g, vga_b}), 0);
            out_h  <= int'(e.h);
            out_v  <= int'(e.v);
            out_en <= e.en;
        end
    end

    // driver tasks
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired, expected event not seen (t=%0t)", name, $time);
    endtask

    task automatic wait_addr(input int h, input int v);
        int t = 0;
        while (!(last_en && last_h == h && last_v == v) && t < 5000) begin
            step();
            t++;
        end
        if (t >= 5000) timeout("wait_addr");
    endtask

    task automatic wait_out(input int h, input int v);
        int t = 0;
        while (!(out_en && out_h == h && out_v == v) && t < 5000) begin
            step();
            t++;
        end
        if (t >= 5000) timeout("wait_out");
    endtask

    function automatic int rep_exp(input int h, input int v);
`ifdef FRAME_SCANOUT_BORDER_EN
        return (h == 0 || v == 0) ? 12'hFFF : 12'h000;
`else
        return (v >= 0 && h < 4) ? 12'hF00 : 12'h0F0;
`endif
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_rgb"}, int'({vga_r, vga_g, vga_b}), 0);
        check({tag, "_hsync"}, int'(hsync), 1);
        check({tag, "_vsync"}, int'(vsync), 1);
        check({tag, "_active"}, int'(active), 0);
        check({tag, "_frame_start"}, int'(frame_start), 0);
        check({tag, "_read_addr"}, int'(read_addr), 0);
    endtask

    // first enabled cycles from the origin: frame_start on cycle 3, line-0 addressing and replication
    task automatic check_startup();
        for (int i = 1; i <= 10; i++) begin
            step();
            check("startup_frame_start", int'(frame_start), (i == 3) ? 1 : 0);
            if (i == 3) check("startup_active", int'(active), 1);
            if (i <= 5) check("startup_read_addr", int'(read_addr), (i == 5) ? 1 : 0);
            if (i >= 3) check("replicate_line0", int'({vga_r, vga_g, vga_b}), rep_exp(i - 3, 0));
        end
    endtask

    int t_cnt, start_h, low_cnt, high_cnt;

    initial begin
        for (int a = 0; a < (1 << AW); a++) begin
`ifdef FRAME_SCANOUT_BORDER_EN
            mem[a] = 12'h000;
`else
            mem[a] = 12'(a * 29 + 291);
`endif
        end
`ifndef FRAME_SCANOUT_BORDER_EN
        mem[0] = 12'hF00;
        mem[1] = 12'h0F0;
`endif
        rstn = 1'b0;
        enable = 1'b1;
        s_en = 1'b1;
        repeat (4) step();
        check_idle("reset");

        rstn = 1'b1;
        check_startup();

`ifdef FRAME_SCANOUT_BORDER_EN
        wait_out(1, 1);
        check("border_inner_1_1", int'({vga_r, vga_g, vga_b}), 12'h000);
        wait_out(639, 1);
        check("border_col_639", int'({vga_r, vga_g, vga_b}), 12'hFFF);
`else
        wait_out(1, 1);
        check("pixel_1_1", int'({vga_r, vga_g, vga_b}), 12'hF00);
`endif

        for (int h = 0; h < 8; h++) begin
            wait_out(h, 3);
            check("replicate_line3", int'({vga_r, vga_g, vga_b}), rep_exp(h, 3));
        end

        wait_addr(639, 3);
        check("addr_639_3", int'(read_addr), 159);
        wait_addr(0, 4);
        check("addr_0_4", int'(read_addr), 160);
        wait_addr(4, 4);
        check("addr_4_4", int'(read_addr), 161);
        wait_addr(639, 4);
        check("addr_639_4", int'(read_addr), 319);

        // hsync: start column, width and period measured on the pins
        wait_out(0, 5);
        t_cnt = 0;
        while (hsync !== 1'b0 && t_cnt < 2000) begin step(); t_cnt++; end
        start_h = out_h;
        check("hsync_start_h", start_h, 656);
        low_cnt = 0;
        while (hsync === 1'b0 && low_cnt < 2000) begin step(); low_cnt++; end
        high_cnt = 0;
        while (hsync === 1'b1 && high_cnt < 2000) begin step(); high_cnt++; end
        check("hsync_low_cycles", low_cnt, 96);
        check("hsync_period", low_cnt + high_cnt, 800);

        // enable dropped while the counter holds h=300
        wait_addr(299, 7);
        enable = 1'b0;
        step();
        check("disable_read_addr", int'(read_addr), 0);
        step();
        check("disable_active_still", int'(active), 1);
        step();
        check_idle("disable");
        repeat (10) step();
        check_idle("disabled_hold");
        enable = 1'b1;
        check_startup();

        // reduced-timing instance: whole-frame vsync and addressing
        t_cnt = 0;
        while (s_vsync !== 1'b1 && t_cnt < 600) begin step(); t_cnt++; end
        while (s_vsync !== 1'b0 && t_cnt < 600) begin step(); t_cnt++; end
        if (t_cnt >= 600) timeout("small_vsync");
        low_cnt = 0;
        while (s_vsync === 1'b0 && low_cnt < 600) begin step(); low_cnt++; end
        high_cnt = 0;
        while (s_vsync === 1'b1 && high_cnt < 600) begin step(); high_cnt++; end
        check("small_vsync_low_cycles", low_cnt, 48);
        check("small_vsync_period", low_cnt + high_cnt, 288);

        t_cnt = 0;
        while (s_frame_start !== 1'b1 && t_cnt < 600) begin step(); t_cnt++; end
        if (t_cnt >= 600) timeout("small_frame_start");
        check("small_fs_active", int'(s_active), 1);
        repeat (94) step();
        check("small_addr_0_4", int'(s_read_addr), 4);
        repeat (87) step();
        check("small_addr_last", int'(s_read_addr), 7);
        step();
        check("small_addr_hblank", int'(s_read_addr), 0);
        repeat (104) step();
        check("small_addr_wrap", int'(s_read_addr), 0);
        repeat (4) step();
        check("small_addr_next_frame", int'(s_read_addr), 1);

        // asynchronous reset mid-frame
        step();
        rstn = 1'b0;
        #1;
        check_idle("async_reset");
        repeat (3) step();
        rstn = 1'b1;
        check_startup();
        repeat (50) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(40 * 60000);
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
